// File: rtl/shift_register_piso_pkg.sv
// Shared widths, counter-width helper and the per-edge operation encoding
// for the parallel-load / serial shift register.
package shift_reg_pkg;

  localparam int SR_W24 = 24;
  localparam int SR_W80 = 80;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  typedef enum logic [1:0] {SR_RST, SR_LOAD, SR_SHIFT, SR_HOLD} sr_op_t;

endpackage

// File: rtl/shift_register_piso_if.sv
// Data/control bundle of the shift register. The shift counter signals
// exist only when SHIFT_REG_BITCNT_EN is defined.
interface shift_register_piso_if
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 24
);

  logic             Ser_In;
  logic [WIDTH-1:0] Par_In;
  logic             Par_load;
  logic             shift_en;
  logic [WIDTH-1:0] Par_out;
  logic             Ser_Out;
`ifdef SHIFT_REG_BITCNT_EN
  logic [cnt_w(WIDTH)-1:0] shift_cnt;
  logic                    shift_done;

  modport master (output Ser_In, Par_In, Par_load, shift_en,
                  input  Par_out, Ser_Out, shift_cnt, shift_done);
  modport slave  (input  Ser_In, Par_In, Par_load, shift_en,
                  output Par_out, Ser_Out, shift_cnt, shift_done);
`else
  modport master (output Ser_In, Par_In, Par_load, shift_en,
                  input  Par_out, Ser_Out);
  modport slave  (input  Ser_In, Par_In, Par_load, shift_en,
                  output Par_out, Ser_Out);
`endif

endinterface

// File: rtl/shift_register_piso_cell.sv
// One register bit: the decoded operation selects clear, parallel bit,
// left neighbour, or hold.
module shift_reg_cell
  import shift_reg_pkg::*;
(
  input  logic   clk,
  input  sr_op_t op,
  input  logic   par_bit,
  input  logic   left_bit,
  output logic   q
);

  always_ff @(posedge clk) begin
    case (op)
      SR_RST:   q <= 1'b0;
      SR_LOAD:  q <= par_bit;
      SR_SHIFT: q <= left_bit;
      default:  q <= q;
    endcase
  end

endmodule

// File: rtl/shift_register_piso.sv
// Parallel-load shift register, serial in at the MSB, serial out at the LSB.
// Define SHIFT_REG_BITCNT_EN to add the saturating shift counter.
module shift_register_piso
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = SR_W24
)(
  input logic                  clk,
  input logic                  rst,
  shift_register_piso_if.slave bus
);

  sr_op_t           op;
  logic [WIDTH:0]   chain;

  // Reset, then load, then shift; everything else holds.
  always_comb begin
    op = SR_HOLD;
    if (rst)               op = SR_RST;
    else if (bus.Par_load) op = SR_LOAD;
    else if (bus.shift_en) op = SR_SHIFT;
  end

  assign chain[WIDTH] = bus.Ser_In;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    shift_reg_cell u_cell (
      .clk      (clk),
      .op       (op),
      .par_bit  (bus.Par_In[i]),
      .left_bit (chain[i+1]),
      .q        (chain[i])
    );
  end

  assign bus.Par_out = chain[WIDTH-1:0];
  assign bus.Ser_Out = chain[0];

`ifdef SHIFT_REG_BITCNT_EN
  localparam int CW = cnt_w(WIDTH);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    case (op)
      SR_RST, SR_LOAD: cnt <= '0;
      SR_SHIFT:        if (cnt != CW'(WIDTH)) cnt <= cnt + 1'b1;
      default:         cnt <= cnt;
    endcase
  end

  assign bus.shift_cnt  = cnt;
  assign bus.shift_done = (cnt == CW'(WIDTH));
`endif

endmodule

// File: tb/tb_shift_register_piso.sv
// Bench for shift_register_piso at WIDTH=24 and WIDTH=80: directed steps
// followed by random traffic against a word-level reference model.
module tb_shift_register_piso;
  import shift_reg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shift_register_piso_if #(.WIDTH(SR_W24)) if24 ();
  shift_register_piso_if #(.WIDTH(SR_W80)) if80 ();

  shift_register_piso #(.WIDTH(SR_W24)) dut24 (.clk(clk), .rst(rst), .bus(if24));
  shift_register_piso #(.WIDTH(SR_W80)) dut80 (.clk(clk), .rst(rst), .bus(if80));

  int n_chk  = 0;
  int n_fail = 0;

  logic [23:0] m24;
  logic [79:0] m80;
  int          c24, c80;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Advance one edge; the model uses only the values the bench drove.
  task automatic tick();
    logic        r, l24, s24, i24, l80, s80, i80;
    logic [23:0] p24;
    logic [79:0] p80;
    r   = rst;
    l24 = if24.Par_load; s24 = if24.shift_en; i24 = if24.Ser_In; p24 = if24.Par_In;
    l80 = if80.Par_load; s80 = if80.shift_en; i80 = if80.Ser_In; p80 = if80.Par_In;
    @(posedge clk);
    if (r)        begin m24 = '0;  c24 = 0; end
    else if (l24) begin m24 = p24; c24 = 0; end
    else if (s24) begin
      m24 = (m24 >> 1) | (24'(i24) << 23);
      c24 = (c24 < 24) ? c24 + 1 : 24;
    end
    if (r)        begin m80 = '0;  c80 = 0; end
    else if (l80) begin m80 = p80; c80 = 0; end
    else if (s80) begin
      m80 = (m80 >> 1) | (80'(i80) << 79);
      c80 = (c80 < 80) ? c80 + 1 : 80;
    end
    #1;
    chk("par24", 80'(if24.Par_out), 80'(m24));
    chk("ser24", 80'(if24.Ser_Out), 80'(m24 % 2));
    chk("par80", if80.Par_out, m80);
    chk("ser80", 80'(if80.Ser_Out), 80'(m80 % 2));
`ifdef SHIFT_REG_BITCNT_EN
    chk("cnt24",  80'(if24.shift_cnt),  80'(c24));
    chk("done24", 80'(if24.shift_done), 80'(c24 == 24));
    chk("cnt80",  80'(if80.shift_cnt),  80'(c80));
    chk("done80", 80'(if80.shift_done), 80'(c80 == 80));
`endif
  endtask

  initial begin
    m24 = '0; m80 = '0; c24 = 0; c80 = 0;
    if24.Ser_In = 0; if24.Par_In = '0; if24.Par_load = 0; if24.shift_en = 0;
    if80.Ser_In = 0; if80.Par_In = '0; if80.Par_load = 0; if80.shift_en = 0;

    rst = 1; tick(); rst = 0;
    chk("rst_par24", 80'(if24.Par_out), 80'h0);
    chk("rst_ser24", 80'(if24.Ser_Out), 80'h0);

    if24.Par_load = 1; if24.Par_In = 24'hA5A5A5; tick(); if24.Par_load = 0;
    chk("load_a5", 80'(if24.Par_out), 80'hA5A5A5);
    chk("load_ser", 80'(if24.Ser_Out), 80'h1);

    if24.shift_en = 1; if24.Ser_In = 1; tick();
    chk("sh1", 80'(if24.Par_out), 80'hD2D2D2);
    repeat (4) tick();
    chk("sh5", 80'(if24.Par_out), 80'hFD2D2D);
    if24.Ser_In = 0; repeat (5) tick();
    chk("sh0x5", 80'(if24.Par_out), 80'h07E969);
    if24.shift_en = 0;

    if80.Par_load = 1; if80.Par_In = 80'h123456789ABCDEF01234; tick(); if80.Par_load = 0;
    chk("load80", if80.Par_out, 80'h123456789ABCDEF01234);
    if80.shift_en = 1; if80.Ser_In = 1; repeat (24) tick(); if80.shift_en = 0;
    chk("sh80", if80.Par_out, 80'hFFFFFF123456789ABCDE);

    if24.Par_load = 1; if24.shift_en = 1; if24.Par_In = 24'h123456; tick();
    if24.Par_load = 0; if24.shift_en = 0;
    chk("prio", 80'(if24.Par_out), 80'h123456);
    repeat (3) tick();
    chk("hold", 80'(if24.Par_out), 80'h123456);

`ifdef SHIFT_REG_BITCNT_EN
    if24.shift_en = 1;
    for (int i = 0; i < 24; i++) begin
      if24.Ser_In = 1'($urandom); tick();
    end
    chk("cnt_full", 80'(if24.shift_cnt), 80'd24);
    chk("cnt_done", 80'(if24.shift_done), 80'd1);
    tick();
    chk("cnt_sat", 80'(if24.shift_cnt), 80'd24);
    if24.shift_en = 0; if24.Par_load = 1; tick(); if24.Par_load = 0;
    chk("cnt_clr", 80'(if24.shift_cnt), 80'd0);
`endif

    if24.shift_en = 1; if24.Ser_In = 1; repeat (3) tick();
    rst = 1; if24.Par_load = 1; if24.Par_In = 24'($urandom); tick();
    rst = 0; if24.Par_load = 0; if24.shift_en = 0;
    chk("rst_mid", 80'(if24.Par_out), 80'h0);

    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 31) == 0);
      if24.Par_load = ($urandom_range(0, 9) == 0);
      if24.shift_en = 1'($urandom);
      if24.Ser_In   = 1'($urandom);
      if24.Par_In   = 24'($urandom);
      if80.Par_load = ($urandom_range(0, 15) == 0);
      if80.shift_en = ($urandom_range(0, 3) != 0);
      if80.Ser_In   = 1'($urandom);
      if80.Par_In   = {16'($urandom), 32'($urandom), 32'($urandom)};
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
